// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundles the fetch request/response, data request/response and shared
//   memory-bus signals that pass through mem_bus_arbiter.
//   Modports:
//     slave  - the arbiter's view (takes ibus/dbus requests and memory
//              completions, drives responses and the shared bus)
//     master - the surrounding core + memory view (the opposite directions)
interface mem_bus_arbiter_if;
  // fetch bus
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  // data bus
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  // shared memory bus
  logic        mem_valid;
  logic        mem_is_write;
  logic [63:0] mem_addr;
  logic [2:0]  mem_size;
  logic [7:0]  mem_strobe;
  logic [63:0] mem_data_w;
  logic        mem_ready;
  logic [63:0] mem_data_r;

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_data_ok, dresp_data,
    output mem_valid, mem_is_write, mem_addr, mem_size, mem_strobe, mem_data_w,
    input  mem_ready, mem_data_r
  );

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_data_ok, dresp_data,
    input  mem_valid, mem_is_write, mem_addr, mem_size, mem_strobe, mem_data_w,
    output mem_ready, mem_data_r
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory bus between instruction fetch (ibus) and the memory
//   stage (dbus). One request is granted at a time, its fields are latched
//   onto the bus, and completion is returned as a one-cycle data_ok pulse.
//   Data requests win over fetches, except that after STARVE_LIMIT
//   consecutive data grants with a fetch waiting, the fetch is forced.
//   Ports:
//     clk    - single clock, rising edge
//     resetn - asynchronous active-low reset
//     bus    - mem_bus_arbiter_if.slave (ibus, dbus and shared memory bus)
//
//   state | meaning
//   IDLE  | no outstanding request, arbitration happens here
//   BUSY  | mem_valid high, waiting for mem_ready
//   DONE  | owner's data_ok pulses, no new grant this cycle
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            resetn,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  localparam logic [2:0] MSIZE4 = 3'd2;

  state_t      state;
  logic        owner;       // 0 = fetch, 1 = data
  logic [2:0]  starve_cnt;
  logic [63:0] rdata_q;

  logic starved;
  logic grant_d;
  logic grant_i;

  assign starved = bus.ireq_valid && (starve_cnt == LIMIT);
  assign grant_d = bus.dreq_valid && !starved;
  assign grant_i = bus.ireq_valid && !grant_d;

  assign bus.iresp_data = rdata_q[31:0];
  assign bus.dresp_data = rdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      owner             <= 1'b0;
      starve_cnt        <= 3'd0;
      rdata_q           <= 64'd0;
      bus.mem_valid     <= 1'b0;
      bus.mem_is_write  <= 1'b0;
      bus.mem_addr      <= 64'd0;
      bus.mem_size      <= 3'd0;
      bus.mem_strobe    <= 8'd0;
      bus.mem_data_w    <= 64'd0;
      bus.iresp_data_ok <= 1'b0;
      bus.dresp_data_ok <= 1'b0;
    end else begin
      // the counter only tracks how long a currently waiting fetch has waited
      if (!bus.ireq_valid) begin
        starve_cnt <= 3'd0;
      end else if (state == IDLE && grant_i) begin
        starve_cnt <= 3'd0;
      end else if (state == IDLE && grant_d && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 3'd1;
      end

      case (state)
        IDLE: begin
          if (grant_d) begin
            owner            <= 1'b1;
            bus.mem_valid    <= 1'b1;
            bus.mem_is_write <= |bus.dreq_strobe;
            bus.mem_addr     <= bus.dreq_addr;
            bus.mem_size     <= bus.dreq_size;
            bus.mem_strobe   <= bus.dreq_strobe;
            bus.mem_data_w   <= bus.dreq_data;
            state            <= BUSY;
          end else if (grant_i) begin
            owner            <= 1'b0;
            bus.mem_valid    <= 1'b1;
            bus.mem_is_write <= 1'b0;
            bus.mem_addr     <= bus.ireq_addr;
            bus.mem_size     <= MSIZE4;
            bus.mem_strobe   <= 8'd0;
            bus.mem_data_w   <= 64'd0;
            state            <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            rdata_q           <= bus.mem_data_r;
            bus.mem_valid     <= 1'b0;
            bus.iresp_data_ok <= !owner;
            bus.dresp_data_ok <= owner;
            state             <= DONE;
          end
        end
        DONE: begin
          bus.iresp_data_ok <= 1'b0;
          bus.dresp_data_ok <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter that shares a single memory bus between the instruction-fetch bus (ibus) and the memory stage's data bus (dbus). It sits between the CPU core and the memory-side bus. It grants one requester at a time, latches that requester's request, drives the shared bus until the memory completes, and returns the result with a one-cycle `data_ok` pulse. Data requests take priority over fetches, with a starvation guard for fetch.

## Interface
- `STARVE_LIMIT`, default 4: consecutive dbus grants allowed while ibus is waiting before ibus is forced.
- `clk` in 1: single clock, all state on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ireq_valid` in 1: fetch request valid; held until `iresp_data_ok`.
- `ireq_addr` in 64: fetch address.
- `iresp_data_ok` out 1: one-cycle completion pulse for fetch.
- `iresp_data` out 32: fetched instruction, `mem_data[31:0]`, valid with `iresp_data_ok`.
- `dreq_valid` in 1: data request valid; held until `dresp_data_ok`.
- `dreq_addr` in 64: data address.
- `dreq_size` in 3: msize code (1/2/4/8 bytes).
- `dreq_strobe` in 8: byte write enables; 0 means a read.
- `dreq_data` in 64: write data, already lane-aligned.
- `dresp_data_ok` out 1: one-cycle completion pulse for data.
- `dresp_data` out 64: raw read data, valid with `dresp_data_ok`.
- `mem_valid` out 1: shared-bus request valid.
- `mem_is_write` out 1: `|strobe` of the latched request.
- `mem_addr` out 64, `mem_size` out 3, `mem_strobe` out 8, `mem_data_w` out 64: latched request fields.
- `mem_ready` in 1: memory completion, sampled only while `mem_valid`.
- `mem_data_r` in 64: read data, valid with `mem_ready`.

## Operation
- FSM states:
  - IDLE: no outstanding request.
  - BUSY: `mem_valid`=1, waiting for `mem_ready`.
  - DONE: pulse `*_data_ok`.
- IDLE, no request valid → stay in IDLE.
- IDLE, one or both requests valid → latch the winner's fields into the bus registers, record `owner` (0=I, 1=D), go to BUSY.
- Fetch latch: `size`=MSIZE4 (3'd2), `strobe`=0, `data`=0, `addr`=`ireq_addr`.
- Arbitration when both are valid: choose D, unless `starve_cnt` == `STARVE_LIMIT`, then choose I.
- `starve_cnt` (3 bits):
  - increments on a D grant while `ireq_valid`=1;
  - clears on any I grant or whenever `ireq_valid`=0;
  - saturates at `STARVE_LIMIT`.
- BUSY, `mem_ready`=1 → capture `mem_data_r` into `rdata_q`, go to DONE. Otherwise hold; all bus outputs stay stable.
- DONE → assert the owner's `data_ok` for exactly one cycle with `rdata_q`, then go to IDLE.
- No new grant is made in DONE, so the requester can drop or change valid.
- Request fields are sampled only at grant. Later changes, or dropping valid mid-transaction, do not affect the bus. The transaction completes and `data_ok` still pulses.
- A write returns `dresp_data` = `mem_data_r` as captured; the core ignores it.

## Timing
- Reset (async, immediate) values:
  - state=IDLE, `mem_valid`=0, `mem_is_write`=0;
  - all `mem_*` fields 0;
  - `iresp_data_ok`=`dresp_data_ok`=0, `iresp_data`=`dresp_data`=0;
  - `starve_cnt`=0, `owner`=0.
- Grant in IDLE at cycle t:
  - `mem_valid`=1 from t+1;
  - if `mem_ready` is seen at cycle t+1+k (k≥0), `data_ok` is high in cycle t+2+k.
- Minimum latency: 2 cycles from valid to `data_ok` (`mem_ready` in the first BUSY cycle).
- Back-to-back throughput: one transaction per 3 cycles minimum (IDLE, BUSY, DONE).
- `mem_valid` deasserts in the cycle after `mem_ready` (DONE state).
- `iresp_data_ok` and `dresp_data_ok` are never high in the same cycle.
- `mem_ready` while not in BUSY is ignored.
- Reset asserted mid-BUSY: bus drops immediately and no `data_ok` is produced. After reset, requesters re-issue.

## Test plan
- **Single read:** `dreq_valid`=1, addr 0x8000_0010, size 3, strobe 0; `mem_ready` on the 3rd BUSY cycle with 0xDEAD_BEEF_0123_4567. Required: `mem_valid` for exactly 3 cycles with the latched fields, then `dresp_data_ok` for 1 cycle with that data; `iresp_data_ok` stays 0.
- **Simultaneous requests:** I (0x8000_0000) and D (0x8000_1000) valid together, `mem_ready` immediate. Required: D served first (`mem_addr`=0x8000_1000). I is granted in the next IDLE, and its `data_ok` arrives 3 cycles after D's.
- **Starvation guard:** `ireq_valid` held and D re-requesting continuously, `STARVE_LIMIT`=4. Required: exactly 4 D transactions, then an I transaction, then D resumes.
- **Request change mid-BUSY:** `dreq_addr` changes to 0x1234 and `dreq_valid` drops while BUSY. Required: `mem_addr` keeps its original value and `dresp_data_ok` still pulses once.
- **Write:** strobe 0x0F, data 0x0000_0000_AABB_CCDD, size 2. Required: `mem_is_write`=1, `mem_strobe`=0x0F, `mem_data_w` as driven.
- **Reset during BUSY:** `resetn`=0 with no clock edge. Required: `mem_valid`=0 immediately, no `data_ok` after release, and a fresh request is served normally.
